// File: rtl/matmul_result_collector.sv
// ---------------------------------------------------------------------------
// matmul_result_collector
//
// Receiving end of the matmul datapath result interface. Captures two complex
// result lanes into per-lane banks, keeps a wrap-around checksum of every
// accepted result, flags completion once both lanes have delivered
// N_PER_LANE results, and offers a registered random-access read port.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle pulse, arms a new collection run
//   valid_in0/1           per-lane result strobes
//   din_R0/I0, din_R1/I1  per-lane signed real/imag result words
//   rd_en, rd_addr        read request; rd_addr MSB = lane, low AW bits = index
//   rd_valid, rd_R, rd_I  read response, one cycle after rd_en
//   busy, done            run status (COLLECT / DONE)
//   overflow              sticky: strobe seen on a full lane (or in DONE)
//   cnt0, cnt1            results captured per lane this run
//   sum_R, sum_I          running mod-2^DW sums of accepted real/imag parts
// ---------------------------------------------------------------------------
module matmul_result_collector #(
    parameter int unsigned DW         = 64,
    parameter int unsigned N_PER_LANE = 16,
    parameter int unsigned AW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          valid_in0,
    input  logic          valid_in1,
    input  logic [DW-1:0] din_R0,
    input  logic [DW-1:0] din_I0,
    input  logic [DW-1:0] din_R1,
    input  logic [DW-1:0] din_I1,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_R,
    output logic [DW-1:0] rd_I,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   cnt0,
    output logic [AW:0]   cnt1,
    output logic [DW-1:0] sum_R,
    output logic [DW-1:0] sum_I
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = 2 * DW;
    localparam logic [AW:0] FULL = CW'(N_PER_LANE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW:0]     cnt0_q, cnt0_d;
    logic [AW:0]     cnt1_q, cnt1_d;
    logic [DW-1:0]   sum_r_q, sum_r_d;
    logic [DW-1:0]   sum_i_q, sum_i_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, done_q;
    logic            we0_c, we1_c;

    logic            rd_valid_q;
    logic [DW-1:0]   rd_r_q, rd_i_q;
    logic [WW-1:0]   rd_word_c;

    // Result banks: {real, imag} per entry, not reset
    logic [WW-1:0]   bank0 [N_PER_LANE];
    logic [WW-1:0]   bank1 [N_PER_LANE];

    // Next-state, capture and checksum logic
    always_comb begin
        state_d = state_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        sum_r_d = sum_r_q;
        sum_i_d = sum_i_q;
        ovf_d   = ovf_q;
        we0_c   = 1'b0;
        we1_c   = 1'b0;

        if (start) begin
            // start wins over any strobe arriving in the same cycle
            state_d = ST_COLLECT;
            cnt0_d  = '0;
            cnt1_d  = '0;
            sum_r_d = '0;
            sum_i_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (valid_in0) begin
                        if (cnt0_q < FULL) begin
                            we0_c   = 1'b1;
                            cnt0_d  = cnt0_q + CW'(1);
                        end else begin
                            ovf_d   = 1'b1;
                        end
                    end
                    if (valid_in1) begin
                        if (cnt1_q < FULL) begin
                            we1_c   = 1'b1;
                            cnt1_d  = cnt1_q + CW'(1);
                        end else begin
                            ovf_d   = 1'b1;
                        end
                    end
                    sum_r_d = sum_r_q + (we0_c ? din_R0 : '0) + (we1_c ? din_R1 : '0);
                    sum_i_d = sum_i_q + (we0_c ? din_I0 : '0) + (we1_c ? din_I1 : '0);
                    if (cnt0_d == FULL && cnt1_d == FULL) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (valid_in0 || valid_in1) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    // IDLE: strobes ignored
                end
            endcase
        end
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            sum_r_q <= '0;
            sum_i_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            sum_r_q <= sum_r_d;
            sum_i_q <= sum_i_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == ST_COLLECT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Bank writes; index is the pre-increment count
    always_ff @(posedge clk) begin
        if (we0_c) begin
            bank0[cnt0_q[AW-1:0]] <= {din_R0, din_I0};
        end
        if (we1_c) begin
            bank1[cnt1_q[AW-1:0]] <= {din_R1, din_I1};
        end
    end

    // Lane select for the read port
    always_comb begin
        rd_word_c = '0;
        if (rd_addr[AW]) begin
            rd_word_c = bank1[rd_addr[AW-1:0]];
        end else begin
            rd_word_c = bank0[rd_addr[AW-1:0]];
        end
    end

    // Registered read port; nonblocking write gives read-before-write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_r_q     <= '0;
            rd_i_q     <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_r_q <= rd_word_c[WW-1:DW];
                rd_i_q <= rd_word_c[DW-1:0];
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_R     = rd_r_q;
    assign rd_I     = rd_i_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;
    assign sum_R    = sum_r_q;
    assign sum_I    = sum_i_q;

endmodule

// File: tb/tb_matmul_result_collector.sv
// ---------------------------------------------------------------------------
// tb_matmul_result_collector
//
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_matmul_result_collector;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, valid_in0, valid_in1, rd_en;
    logic [DW-1:0] din_R0, din_I0, din_R1, din_I1;
    logic [AW:0]   rd_addr;
    logic          rd_valid, busy, done, overflow;
    logic [DW-1:0] rd_R, rd_I, sum_R, sum_I;
    logic [AW:0]   cnt0, cnt1;

    always #5 clk = ~clk;

    matmul_result_collector #(.DW(DW), .N_PER_LANE(16), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .valid_in0(valid_in0), .valid_in1(valid_in1),
        .din_R0(din_R0), .din_I0(din_I0), .din_R1(din_R1), .din_I1(din_I1),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_R(rd_R), .rd_I(rd_I),
        .busy(busy), .done(done), .overflow(overflow),
        .cnt0(cnt0), .cnt1(cnt1), .sum_R(sum_R), .sum_I(sum_I)
    );

    typedef struct {
        logic          rst_n, start, v0, v1, rd_en;
        logic [63:0]   r0, i0, r1, i1;
        logic [4:0]    rd_addr;
        logic          e_busy, e_done, e_ovf, e_rdv, chk_rd;
        logic [4:0]    e_cnt0, e_cnt1;
        logic [63:0]   e_sum_r, e_sum_i, e_rd_r, e_rd_i;
    } vec_t;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    vec_t        tbl[$];
    vec_t        cur;
    logic        m_busy, m_done, m_ovf;
    logic [4:0]  m_c0, m_c1;
    logic [63:0] m_sr, m_si;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic new_vec();
        cur = '{default: '0};
        cur.rst_n = 1'b1;
    endtask

    task automatic clr_model();
        m_c0 = '0; m_c1 = '0; m_sr = '0; m_si = '0; m_ovf = 1'b0;
    endtask

    task automatic push();
        cur.e_busy  = m_busy;
        cur.e_done  = m_done;
        cur.e_ovf   = m_ovf;
        cur.e_cnt0  = m_c0;
        cur.e_cnt1  = m_c1;
        cur.e_sum_r = m_sr;
        cur.e_sum_i = m_si;
        cur.e_rdv   = cur.rst_n & cur.rd_en;
        tbl.push_back(cur);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0; rd_en = 1'b0;
        din_R0 = '0; din_I0 = '0; din_R1 = '0; din_I1 = '0; rd_addr = '0;
        m_busy = 1'b0; m_done = 1'b0;
        clr_model();

        // Scenario 1: reset, start, alternate-lane fill (R=k/100+k, I=-k)
        new_vec(); cur.rst_n = 1'b0; cur.chk_rd = 1'b1; push();
        new_vec(); cur.start = 1'b1; m_busy = 1'b1; push();
        for (int k = 0; k < 16; k++) begin
            new_vec(); cur.v0 = 1'b1; cur.r0 = 64'(k); cur.i0 = 64'(-k);
            m_c0 = m_c0 + 5'd1; m_sr = m_sr + 64'(k); m_si = m_si - 64'(k);
            push();
            new_vec(); cur.v1 = 1'b1; cur.r1 = 64'(100 + k); cur.i1 = 64'(-k);
            m_c1 = m_c1 + 5'd1; m_sr = m_sr + 64'(100 + k); m_si = m_si - 64'(k);
            if (k == 15) begin m_busy = 1'b0; m_done = 1'b1; end
            push();
        end
        // Both lanes contribute: sum_R = 120 + 1720 = 1840, sum_I = -240

        // Scenario 2: read back all 32 entries, then hold
        for (int a = 0; a < 32; a++) begin
            new_vec(); cur.rd_en = 1'b1; cur.rd_addr = 5'(a); cur.chk_rd = 1'b1;
            cur.e_rd_r = (a < 16) ? 64'(a) : 64'(100 + a - 16);
            cur.e_rd_i = 64'(-(a % 16));
            push();
        end
        new_vec(); cur.chk_rd = 1'b1; cur.e_rd_r = 64'd115; cur.e_rd_i = 64'(-15); push();

        // Strobe while DONE: overflow only
        new_vec(); cur.v1 = 1'b1; cur.r1 = 64'd999; m_ovf = 1'b1; push();

        // Scenario 6: start in DONE with a coincident lane-0 strobe
        new_vec(); cur.start = 1'b1; cur.v0 = 1'b1; cur.r0 = 64'd55; cur.i0 = 64'd66;
        clr_model(); m_busy = 1'b1; m_done = 1'b0; push();

        // Scenario 3: both lanes each cycle with max positive real; sum wraps to -2n
        for (int n = 1; n <= 16; n++) begin
            new_vec(); cur.v0 = 1'b1; cur.v1 = 1'b1;
            cur.r0 = MAXP; cur.r1 = MAXP; cur.i0 = 64'd1; cur.i1 = 64'd1;
            m_c0 = 5'(n); m_c1 = 5'(n); m_sr = 64'(-2 * n); m_si = 64'(2 * n);
            if (n == 16) begin m_busy = 1'b0; m_done = 1'b1; end
            push();
        end
        new_vec(); cur.rd_en = 1'b1; cur.rd_addr = 5'd19; cur.chk_rd = 1'b1;
        cur.e_rd_r = MAXP; cur.e_rd_i = 64'd1; push();

        // Scenario 4: lane 0 fills first, 17th lane-0 strobe dropped
        new_vec(); cur.start = 1'b1; clr_model(); m_busy = 1'b1; m_done = 1'b0; push();
        for (int k = 0; k < 10; k++) begin
            new_vec(); cur.v0 = 1'b1; cur.v1 = 1'b1;
            cur.r0 = 64'd1; cur.i0 = 64'd1; cur.r1 = 64'd1; cur.i1 = 64'd1;
            m_c0 = m_c0 + 5'd1; m_c1 = m_c1 + 5'd1; m_sr = m_sr + 64'd2; m_si = m_si + 64'd2;
            push();
        end
        for (int k = 0; k < 6; k++) begin
            new_vec(); cur.v0 = 1'b1; cur.r0 = 64'd1; cur.i0 = 64'd1;
            m_c0 = m_c0 + 5'd1; m_sr = m_sr + 64'd1; m_si = m_si + 64'd1;
            push();
        end
        new_vec(); cur.v0 = 1'b1; cur.r0 = 64'd1000; cur.i0 = 64'd1000; m_ovf = 1'b1; push();
        for (int k = 0; k < 6; k++) begin
            new_vec(); cur.v1 = 1'b1; cur.r1 = 64'd1; cur.i1 = 64'd1;
            m_c1 = m_c1 + 5'd1; m_sr = m_sr + 64'd1; m_si = m_si + 64'd1;
            if (k == 0) begin
                // Same-cycle read of bank1[10] while it is written: old data
                cur.rd_en = 1'b1; cur.rd_addr = 5'd26; cur.chk_rd = 1'b1;
                cur.e_rd_r = MAXP; cur.e_rd_i = 64'd1;
            end else if (k == 1) begin
                cur.rd_en = 1'b1; cur.rd_addr = 5'd26; cur.chk_rd = 1'b1;
                cur.e_rd_r = 64'd1; cur.e_rd_i = 64'd1;
            end
            if (k == 5) begin m_busy = 1'b0; m_done = 1'b1; end
            push();
        end

        // Scenario 5: reset mid-run with cnt0=5, strobes ignored until start
        new_vec(); cur.start = 1'b1; clr_model(); m_busy = 1'b1; m_done = 1'b0; push();
        for (int k = 0; k < 5; k++) begin
            new_vec(); cur.v0 = 1'b1; cur.r0 = 64'd3; cur.i0 = 64'd4;
            m_c0 = m_c0 + 5'd1; m_sr = m_sr + 64'd3; m_si = m_si + 64'd4;
            push();
        end
        new_vec(); cur.rst_n = 1'b0; cur.v0 = 1'b1; cur.r0 = 64'd3; cur.rd_en = 1'b1;
        cur.chk_rd = 1'b1; clr_model(); m_busy = 1'b0; push();
        for (int k = 0; k < 2; k++) begin
            new_vec(); cur.v0 = 1'b1; cur.v1 = 1'b1; cur.r0 = 64'd9; cur.r1 = 64'd9;
            cur.chk_rd = 1'b1; push();
        end
        new_vec(); cur.start = 1'b1; m_busy = 1'b1; push();
        new_vec(); cur.v1 = 1'b1; cur.r1 = 64'd7; cur.i1 = 64'(-7);
        m_c1 = 5'd1; m_sr = 64'd7; m_si = 64'(-7); push();

        // Apply and compare
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n     = tbl[i].rst_n;
            start     = tbl[i].start;
            valid_in0 = tbl[i].v0;
            valid_in1 = tbl[i].v1;
            din_R0    = tbl[i].r0;
            din_I0    = tbl[i].i0;
            din_R1    = tbl[i].r1;
            din_I1    = tbl[i].i1;
            rd_en     = tbl[i].rd_en;
            rd_addr   = tbl[i].rd_addr;
            @(posedge clk);
            #1;
            n_vec++;
            chk("busy",     i, 64'(busy),     64'(tbl[i].e_busy));
            chk("done",     i, 64'(done),     64'(tbl[i].e_done));
            chk("overflow", i, 64'(overflow), 64'(tbl[i].e_ovf));
            chk("cnt0",     i, 64'(cnt0),     64'(tbl[i].e_cnt0));
            chk("cnt1",     i, 64'(cnt1),     64'(tbl[i].e_cnt1));
            chk("sum_R",    i, sum_R,         tbl[i].e_sum_r);
            chk("sum_I",    i, sum_I,         tbl[i].e_sum_i);
            chk("rd_valid", i, 64'(rd_valid), 64'(tbl[i].e_rdv));
            if (tbl[i].chk_rd) begin
                chk("rd_R", i, rd_R, tbl[i].e_rd_r);
                chk("rd_I", i, rd_I, tbl[i].e_rd_i);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
